// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Converts EX/MEM control and data into a single
// req/ack data-memory transaction (byte/half/word stores with strobes, loads with sign/zero
// extension), stalls upstream while a transaction is outstanding and drives MEM/WB.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   incrementPCIn               PC+4 from EX/MEM
//   ALUResIn                    ALU result / byte address
//   RS2In                       store data
//   rdIn, ru_writeIn            destination register and register-file write enable
//   dm_writeIn                  1 = store
//   dm_ctrlIn                   funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ru_data_srcIn               writeback select: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   mem_req/we/addr/wdata/wstrb registered bus request
//   mem_ack, mem_rdata          completion pulse and read word
//   stall                       combinational freeze of upstream stages
//   wb_data, wb_rd, wb_we       MEM/WB register
//   misalign_err, bus_err       registered one-cycle error pulses
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] incrementPCIn,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] RS2In,
  input  logic [4:0]  rdIn,
  input  logic        ru_writeIn,
  input  logic        dm_writeIn,
  input  logic [2:0]  dm_ctrlIn,
  input  logic [1:0]  ru_data_srcIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_we_q, misalign_q, bus_err_q;

  logic        is_load, access, size_w, size_h, is_unsigned, misaligned;
  logic        wb_we_nom, timeout_hit;
  logic [31:0] st_wdata, ld_shift, ld_ext, nonload_data;
  logic [3:0]  st_wstrb;
  logic [15:0] ld_half;

  assign is_load     = (ru_data_srcIn == 2'b01);
  assign access      = dm_writeIn | is_load;
  // Reserved encodings 011/110/111 fall into the word class via bit 1.
  assign size_w      = dm_ctrlIn[1];
  assign size_h      = ~dm_ctrlIn[1] & dm_ctrlIn[0];
  assign is_unsigned = dm_ctrlIn[2] & ~dm_ctrlIn[1];
  assign misaligned  = (size_w & (|ALUResIn[1:0])) | (size_h & ALUResIn[0]);
  assign wb_we_nom   = ru_writeIn & (rdIn != 5'd0);
  assign timeout_hit = (cnt_q == CntLast) & ~mem_ack;

  // Store lane replication and strobes.
  always_comb begin
    st_wdata = RS2In;
    st_wstrb = 4'b1111;
    if (size_h) begin
      st_wdata = {2{RS2In[15:0]}};
      st_wstrb = ALUResIn[1] ? 4'b1100 : 4'b0011;
    end else if (!size_w) begin
      st_wdata = {4{RS2In[7:0]}};
      st_wstrb = 4'b0001 << ALUResIn[1:0];
    end
  end

  // Load lane extraction and extension.
  assign ld_shift = mem_rdata >> {ALUResIn[1:0], 3'b000};
  assign ld_half  = ALUResIn[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    if (size_h) begin
      ld_ext = {{16{ld_half[15] & ~is_unsigned}}, ld_half};
    end else if (!size_w) begin
      ld_ext = {{24{ld_shift[7] & ~is_unsigned}}, ld_shift[7:0]};
    end
  end

  assign nonload_data = (ru_data_srcIn == 2'b10) ? incrementPCIn : ALUResIn;

  // The final cycle of an access (ack or timeout) never stalls so EX/MEM advances with it.
  always_comb begin
    if (state_q == StIdle) begin
      stall = access & ~misaligned;
    end else begin
      stall = ~mem_ack & ~timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      wb_data_q   <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wb_rd_q <= rdIn;
          if (!access) begin
            wb_data_q <= nonload_data;
            wb_we_q   <= wb_we_nom;
          end else if (misaligned) begin
            wb_data_q  <= ALUResIn;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b1;
          end else begin
            // Launch the bus cycle; MEM/WB takes a bubble meanwhile.
            wb_data_q   <= ALUResIn;
            wb_we_q     <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_writeIn;
            mem_addr_q  <= {ALUResIn[31:2], 2'b00};
            mem_wdata_q <= dm_writeIn ? st_wdata : 32'd0;
            mem_wstrb_q <= dm_writeIn ? st_wstrb : 4'd0;
            cnt_q       <= 8'd0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'd0;
            wb_rd_q     <= rdIn;
            wb_we_q     <= wb_we_nom & ~dm_writeIn;
            wb_data_q   <= (is_load & ~dm_writeIn) ? ld_ext : ALUResIn;
            state_q     <= StIdle;
          end else if (timeout_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'd0;
            wb_rd_q     <= rdIn;
            wb_we_q     <= 1'b0;
            wb_data_q   <= ALUResIn;
            bus_err_q   <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_we        = wb_we_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
